// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the byte-stream handshake from the serial receiver, the
//   instruction-memory write port and the loader status outputs.
//
//   rx_data     [7:0]        byte from the receiver
//   rx_valid                 rx_data is valid
//   rx_ready                 loader accepts a byte (rx_valid & rx_ready consumes)
//   imem_we                  one-cycle write strobe to instruction memory
//   imem_addr   [ADDR_W-1:0] write address
//   imem_wdata  [31:0]       instruction word
//   cpu_hold                 holds the core in reset/stall while high
//   done                     a valid image is loaded
//   err                      the last frame was rejected
//   word_count  [7:0]        words written in the current or last frame
//
//   master : the loader side (drives rx_ready, memory port and status)
//   slave  : the environment side (receiver, memory, core)
// ----------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    logic [7:0]        word_count;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output cpu_hold,
        output done,
        output err,
        output word_count
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  cpu_hold,
        input  done,
        input  err,
        input  word_count
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Program loader for the instruction memory of the 32-bit core. Parses a
//   framed byte stream (SYNC, length N, 4N big-endian payload bytes, XOR
//   checksum), writes each assembled word to consecutive addresses starting
//   at 0, and keeps cpu_hold high until a frame with a good checksum has
//   been fully received.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   imem_loader_if.master: receiver handshake (rx_data/rx_valid/
//           rx_ready), memory write port (imem_we/imem_addr/imem_wdata) and
//           status (cpu_hold/done/err/word_count)
//
//   Parameters:
//     DEPTH   instruction memory words; legal frame length is 1..DEPTH
//     ADDR_W  imem_addr width, 2^ADDR_W >= DEPTH; must match the interface
//     SYNC    frame start byte
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int         DEPTH  = 31,
    parameter int         ADDR_W = 5,
    parameter logic [7:0] SYNC   = 8'hA5
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam logic [7:0] MAX_LEN = 8'(DEPTH);

    logic [2:0]        state_q,    state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              hold_q,     hold_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [7:0]        wcount_q,   wcount_d;
    logic [7:0]        len_q,      len_d;
    logic [1:0]        bidx_q,     bidx_d;
    logic [7:0]        csum_q,     csum_d;

    logic              hs;

    assign hs = bus.rx_valid & rx_ready_q;

    always_comb begin
        state_d    = state_q;
        rx_ready_d = 1'b1;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        hold_d     = hold_q;
        done_d     = done_q;
        err_d      = err_q;
        wcount_d   = wcount_q;
        len_d      = len_q;
        bidx_d     = bidx_q;
        csum_d     = csum_q;

        if (we_q) begin
            // The write cycle is ending: step to the next word slot. rx_ready
            // was held low during this cycle, so no byte can arrive here.
            addr_d   = addr_q + ADDR_W'(1);
            wcount_d = wcount_q + 8'd1;
            if (wcount_d == len_q) begin
                state_d = S_CSUM;
            end
        end else if (hs) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == SYNC) begin
                        state_d = S_LEN;
                    end
                end

                S_LEN: begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        hold_d  = 1'b1;
                    end else begin
                        state_d  = S_DATA;
                        len_d    = bus.rx_data;
                        wcount_d = 8'd0;
                        addr_d   = '0;
                        bidx_d   = 2'd0;
                        csum_d   = 8'd0;
                    end
                end

                S_DATA: begin
                    // Big-endian: the first byte of a word ends up in [31:24].
                    wdata_d = {wdata_q[23:0], bus.rx_data};
                    csum_d  = csum_q ^ bus.rx_data;
                    bidx_d  = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Drop rx_ready for the write cycle so the address and
                        // count can advance before the next byte is taken.
                        we_d       = 1'b1;
                        rx_ready_d = 1'b0;
                    end
                end

                S_CSUM: begin
                    if (bus.rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                        hold_d  = 1'b1;
                    end
                end

                S_DONE: begin
                    // Reload: stall the core again as soon as a new frame starts.
                    if (bus.rx_data == SYNC) begin
                        state_d = S_LEN;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                    end
                end

                S_ERROR: begin
                    if (bus.rx_data == SYNC) begin
                        state_d = S_LEN;
                        err_d   = 1'b0;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wcount_q   <= 8'd0;
            len_q      <= 8'd0;
            bidx_q     <= 2'd0;
            csum_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wcount_q   <= wcount_d;
            len_q      <= len_d;
            bidx_q     <= bidx_d;
            csum_q     <= csum_d;
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = wcount_q;

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
//   Drives framed byte streams into imem_loader and checks the memory writes
//   and status against expectations derived from the frame contents (words,
//   length, XOR of payload bytes).
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int         ADDR_W = 5;
    localparam int         DEPTH  = 31;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic clk;
    logic rst;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .SYNC  (SYNC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    logic [ADDR_W+31:0] got[$];
    logic [31:0]        wq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Write monitor and rx_ready / imem_we relationship.
    initial begin
        bit prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                checks++;
                if (bus.rx_ready !== ~bus.imem_we) begin
                    errors++;
                    $display("FAIL ready_vs_we: rx_ready=%b imem_we=%b (need rx_ready = !imem_we)",
                             bus.rx_ready, bus.imem_we);
                end
                checks++;
                if (bus.imem_we === 1'b1 && prev_we) begin
                    errors++;
                    $display("FAIL we_width: imem_we high 2 cycles in a row, need 1");
                end
                if (bus.imem_we === 1'b1) got.push_back({bus.imem_addr, bus.imem_wdata});
            end
            prev_we = (bus.imem_we === 1'b1);
        end
    end

    // Called at a negedge; returns at the negedge after the consuming edge.
    task automatic send(input logic [7:0] b, input int maxgap);
        int g;
        int t;
        g = int'($urandom_range(maxgap, 0));
        t = 0;
        bus.rx_valid = 1'b0;
        repeat (g) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, need <20", b, t);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (bus.rx_ready !== 1'b0 || bus.imem_we !== 1'b0 || bus.imem_addr !== '0 ||
            bus.imem_wdata !== 32'd0 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.word_count !== 8'd0) begin
            errors++;
            $display("FAIL %s: rdy=%b we=%b addr=%0d wd=%h hold=%b done=%b err=%b wc=%0d, need 0 0 0 0 1 0 0 0",
                     tag, bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata,
                     bus.cpu_hold, bus.done, bus.err, bus.word_count);
        end
    endtask

    // Sends one complete frame built from words and checks writes and status.
    // csum_sel < 0 sends the correct checksum, otherwise that byte value.
    task automatic run_frame(input logic [31:0] words[$], input int csum_sel,
                             input int maxgap, input string tag);
        logic [7:0]  x;
        logic [7:0]  cb;
        logic [31:0] w;
        int          n;
        bit          bad;
        n = words.size();
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = words[i];
            x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        cb  = (csum_sel < 0) ? x : 8'(csum_sel);
        bad = (cb != x);
        got.delete();

        send(SYNC, maxgap);
        checks++;
        if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL %s_sync: hold=%b done=%b err=%b, need 1 0 0",
                     tag, bus.cpu_hold, bus.done, bus.err);
        end
        send(8'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            send(w[31:24], maxgap);
            send(w[23:16], maxgap);
            send(w[15:8], maxgap);
            send(w[7:0], maxgap);
            checks++;
            if (bus.imem_we !== 1'b1 || bus.imem_addr !== ADDR_W'(i) || bus.imem_wdata !== w) begin
                errors++;
                $display("FAIL %s_wr%0d: we=%b addr=%0d data=%h, need 1 %0d %h",
                         tag, i, bus.imem_we, bus.imem_addr, bus.imem_wdata, i, w);
            end
        end
        send(cb, maxgap);

        checks++;
        if (got.size() != n) begin
            errors++;
            $display("FAIL %s_nwrites: %0d, need %0d", tag, got.size(), n);
        end
        for (int i = 0; i < n && i < got.size(); i++) begin
            checks++;
            if (got[i] !== {ADDR_W'(i), words[i]}) begin
                errors++;
                $display("FAIL %s_log%0d: %h, need %h", tag, i, got[i], {ADDR_W'(i), words[i]});
            end
        end
        checks++;
        if (bus.done !== !bad || bus.err !== bad || bus.cpu_hold !== bad) begin
            errors++;
            $display("FAIL %s_status: done=%b err=%b hold=%b, need %b %b %b",
                     tag, bus.done, bus.err, bus.cpu_hold, !bad, bad, bad);
        end
        checks++;
        if (bus.word_count !== 8'(n) || bus.imem_addr !== ADDR_W'(n)) begin
            errors++;
            $display("FAIL %s_count: wc=%0d addr=%0d, need %0d %0d",
                     tag, bus.word_count, bus.imem_addr, n, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        #1;
        checks++;
        if (bus.rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: %b, need 0", bus.rx_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: %b, need 1", bus.rx_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_load();
        wq = '{32'h11000000, 32'h10000001};
        run_frame(wq, -1, 0, "load");
    endtask

    task automatic test_bad_csum();
        wq = '{32'h11000000, 32'h10000001};
        run_frame(wq, 8'h5A, 0, "badcsum");
    endtask

    task automatic test_bad_len();
        got.delete();
        send(SYNC, 0);
        send(8'h00, 0);
        checks++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL badlen0: err=%b done=%b hold=%b, need 1 0 1", bus.err, bus.done, bus.cpu_hold);
        end
        send(SYNC, 0);
        checks++;
        if (bus.err !== 1'b0) begin
            errors++;
            $display("FAIL badlen_clear: err=%b, need 0", bus.err);
        end
        send(8'h20, 0);
        checks++;
        if (bus.err !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL badlen32: err=%b done=%b hold=%b, need 1 0 1", bus.err, bus.done, bus.cpu_hold);
        end
        checks++;
        if (got.size() != 0) begin
            errors++;
            $display("FAIL badlen_writes: %0d, need 0", got.size());
        end
        wq = '{32'hDEADBEEF};
        run_frame(wq, -1, 0, "after_badlen");
    endtask

    task automatic test_gaps();
        int n;
        int cs;
        wq = '{32'h11000000, 32'h10000001};
        run_frame(wq, -1, 5, "gaps2");
        for (int f = 0; f < 6; f++) begin
            n = (f == 0) ? DEPTH : (f == 1) ? 1 : int'($urandom_range(DEPTH, 1));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            if (f == 2) wq[0] = 32'hA5A5A5A5;
            cs = ((f % 3) == 1) ? -2 : -1;
            if (cs == -2) begin
                // Corrupt the checksum by a nonzero XOR offset of the correct one.
                logic [7:0] x;
                logic [31:0] w;
                x = 8'd0;
                for (int i = 0; i < n; i++) begin
                    w = wq[i];
                    x = x ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                end
                cs = int'(x ^ 8'($urandom_range(255, 1)));
            end
            run_frame(wq, cs, 5, "rand");
        end
    endtask

    task automatic test_reset_mid();
        send(SYNC, 0);
        send(8'h02, 0);
        for (int i = 0; i < 5; i++) send(8'($urandom), 2);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("reset_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        wq = '{$urandom, $urandom};
        run_frame(wq, -1, 1, "after_rst");
    endtask

    task automatic test_reload_noise();
        do_reset();
        got.delete();
        send(8'h00, 0);
        send(8'hFF, 1);
        send(8'h12, 0);
        checks++;
        if (got.size() != 0 || bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL noise: writes=%0d hold=%b done=%b err=%b, need 0 1 0 0",
                     got.size(), bus.cpu_hold, bus.done, bus.err);
        end
        wq = '{32'h01234567, 32'h89ABCDEF};
        run_frame(wq, -1, 0, "noise_load");
        wq = '{32'hFFFFFFFF};
        run_frame(wq, 8'h00, 0, "reload");
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst          = 1'b1;
        test_reset();
        test_load();
        test_bad_csum();
        test_bad_len();
        test_gaps();
        test_reset_mid();
        test_reload_noise();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader writing instruction memory for the 32-bit pipelined core. It consumes a framed byte stream from the serial receiver and assembles big-endian 32-bit instruction words. It writes those words sequentially into instruction memory from address 0, verifies an XOR checksum, and holds the core in reset until a complete, valid image has been loaded. It is the write side of the instruction-memory port that the core's fetch stage reads.

## Interface

Parameters:
- DEPTH, 31: instruction memory words; legal frame length is 1..DEPTH.
- ADDR_W, 5: imem_addr width; must satisfy 2^ADDR_W >= DEPTH.
- SYNC, 8'hA5: frame start byte.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rx_data  in  8  byte from the receiver
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts a byte; a byte is consumed on a rising edge where rx_valid & rx_ready
- imem_we  out  1  one-cycle write strobe to instruction memory
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  instruction word
- cpu_hold  out  1  holds the core in reset/stall while high
- done  out  1  a valid image is loaded
- err  out  1  the last frame was rejected
- word_count  out  8  words written in the current or last frame

## Operation

- Frame format: SYNC, then length byte N, then 4N payload bytes (big-endian, MSB byte first per word), then checksum byte C. C must equal the XOR of all 4N payload bytes.
- States:
  - IDLE: discard every byte except SYNC. On SYNC, go to LEN.
  - LEN: if N==0 or N>DEPTH, go to ERROR. Otherwise latch N, clear word_count, addr, byte index and running XOR, then go to DATA.
  - DATA: shift each byte into the word register (wdata <= {wdata[23:0], byte}) and update the XOR. On the 4th byte of a word, pulse imem_we with the current addr and assembled word. After that write, increment addr and word_count. When word_count reaches N, go to CSUM.
  - CSUM: if the byte equals the XOR, go to DONE. Otherwise go to ERROR.
  - DONE: done=1, cpu_hold=0. A SYNC byte goes to LEN and sets cpu_hold=1, done=0 (reload).
  - ERROR: err=1, cpu_hold=1. A SYNC byte goes to LEN and clears err. Other bytes are discarded.
- Memory is written before the checksum is verified. On error the partial image stays in memory but is never executed, because cpu_hold remains high.
- err and done are never high together. err is cleared only by SYNC or reset.
- Bytes with rx_ready low are not consumed. The sender holds each byte until it is accepted.

## Timing

- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0, state=IDLE.
- rx_ready rises on the first clk edge after rst falls.
- rx_ready is low for exactly the one cycle in which imem_we is high; it is high in every other cycle.
- imem_we is high for exactly one cycle. It starts on the edge that consumes the 4th byte of a word, with imem_addr and imem_wdata valid in that same cycle.
- imem_addr and word_count increment on the edge that ends the imem_we cycle.
- Write latency: the word appears on the port 0 cycles after its last byte's handshake edge, i.e. in the registered cycle that follows that edge.
- done/err/cpu_hold update on the same edge that consumes the checksum byte (or the bad length byte).
- A minimum frame of N words takes 4N+3 handshakes plus N write cycles.
- Gaps in rx_valid are allowed anywhere and only stretch the frame; there is no timeout.
- rst asserted mid-frame immediately forces all reset values, cpu_hold=1. Any partial memory writes remain.
- SYNC inside DATA or CSUM is treated as payload or checksum, not as a restart.

## Test plan

- Load: A5 02 11 00 00 00 10 00 00 01 00 -> imem_we pulses at addr 0 with 0x11000000, then addr 1 with 0x10000001. Then done=1, cpu_hold=0, err=0, word_count=2.
- Bad checksum: same frame with final byte 0x5A -> both words are written, then err=1, done=0, cpu_hold=1.
- Bad length: A5 00, and separately A5 20 (32 > DEPTH) -> err=1 and no imem_we. A following valid frame clears err and ends with done=1.
- Backpressure/gaps: insert random 0-5 cycle rx_valid gaps in the two-word frame -> identical writes and result. No byte is lost or duplicated, and rx_ready is low only during the imem_we cycles.
- Reset mid-frame: rst after 5 payload bytes -> all outputs return to reset values. A new full frame then loads correctly from addr 0.
- Reload and noise: garbage bytes (00 FF 12) in IDLE are ignored. After done, send A5 01 FF FF FF FF 00 -> cpu_hold rises on the LEN entry, addr 0 is written with 0xFFFFFFFF, and the frame ends with done=1.
